// File: rtl/apb4_reg_native_bridge_pkg.sv
// Shared types and width helpers for the APB4-to-native register bridge.
package apb2reg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  localparam int ALIGN_LSB_32 = 2;
  localparam int ALIGN_LSB_64 = 3;

  function automatic int strb_w(input int dw);
    return dw / 8;
  endfunction

  function automatic int align_lsbs(input int dw);
    return (dw == 64) ? ALIGN_LSB_64 : ALIGN_LSB_32;
  endfunction

endpackage

// File: rtl/apb4_reg_native_bridge_if.sv
// APB4 bus bundle; the bridge sits on the slave modport.
interface apb4_reg_native_bridge_if #(
  parameter int ADDR_WIDTH = 48,
  parameter int DATA_WIDTH = 32
);
  logic                    psel;
  logic                    penable;
  logic                    pwrite;
  logic [ADDR_WIDTH-1:0]   paddr;
  logic [DATA_WIDTH-1:0]   pwdata;
  logic [DATA_WIDTH/8-1:0] pstrb;
  logic [2:0]              pprot;
  logic                    pready;
  logic [DATA_WIDTH-1:0]   prdata;
  logic                    pslverr;

  modport master (output psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
                  input  pready, prdata, pslverr);
  modport slave  (input  psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
                  output pready, prdata, pslverr);
endinterface

// File: rtl/apb4_reg_native_bridge_timeout_cnt.sv
// Ack-wait counter: loads 1 while cleared, counts while enabled, flags expiry.
module apb2reg_timeout_cnt #(
  parameter int TIMEOUT_CYCLES = 1023,
  parameter int TIMEOUT_WIDTH  = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);
  if (TIMEOUT_CYCLES == 0) begin : g_off
    logic unused_in;
    assign unused_in = clk_i ^ rst_ni ^ clear_i ^ enable_i;
    assign expire_o  = 1'b0;
  end else begin : g_on
    logic [TIMEOUT_WIDTH-1:0] cnt_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)       cnt_q <= '0;
      else if (clear_i)  cnt_q <= TIMEOUT_WIDTH'(1);
      else if (enable_i) cnt_q <= cnt_q + 1'b1;
    end
    // >= so a threshold of 1 still fires on the first wait cycle
    assign expire_o = (cnt_q >= TIMEOUT_WIDTH'(TIMEOUT_CYCLES));
  end
endmodule

// File: rtl/apb4_reg_native_bridge.sv
// APB4 slave to native req/ack bridge. Optional security check: APB2REG_SEC_CHECK_EN.
module apb4_reg_native_bridge
  import apb2reg_pkg::*;
#(
  parameter int ADDR_WIDTH     = 48,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1023,
  parameter int TIMEOUT_WIDTH  = 16
) (
  input  logic                    pclk_i,
  input  logic                    presetn_i,
  apb4_reg_native_bridge_if.slave apb,
  output logic                    req_vld_o,
  input  logic                    ack_vld_i,
  output logic                    wr_en_o,
  output logic                    rd_en_o,
  output logic [ADDR_WIDTH-1:0]   addr_o,
  output logic [DATA_WIDTH-1:0]   wr_data_o,
  output logic [strb_w(DATA_WIDTH)-1:0] wr_be_o,
  input  logic [DATA_WIDTH-1:0]   rd_data_i,
  input  logic                    err_i,
  output logic                    non_sec_o,
  input  logic                    domain_is_non_secure_i,
  input  logic                    error_report_en_i,
  output logic                    timeout_pulse_o
);
  localparam int SW = strb_w(DATA_WIDTH);
  localparam int AL = align_lsbs(DATA_WIDTH);

  state_e                  state_q;
  logic                    req_vld_q, wr_en_q, rd_en_q, non_sec_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q, rdata_q;
  logic [SW-1:0]           be_q;
  logic                    pready_q, err_q, to_q;
  logic                    setup, misalign, zero_strb, sec_viol, expire, done;
  logic                    unused_sig;

  assign setup     = apb.psel & ~apb.penable;
  assign misalign  = |apb.paddr[AL-1:0];
  assign zero_strb = apb.pwrite & ~|apb.pstrb;

`ifdef APB2REG_SEC_CHECK_EN
  assign sec_viol   = apb.pprot[1] & ~domain_is_non_secure_i;
  assign unused_sig = apb.pprot[0] ^ apb.pprot[2];
`else
  assign sec_viol   = 1'b0;
  assign unused_sig = apb.pprot[0] ^ apb.pprot[2] ^ domain_is_non_secure_i;
`endif

  // Ack beats a same-cycle expiry; the timeout only counts in WAIT.
  assign done = ack_vld_i | ((state_q == ST_WAIT) & expire);

  apb2reg_timeout_cnt #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TIMEOUT_WIDTH  (TIMEOUT_WIDTH)
  ) u_tmo (
    .clk_i    (pclk_i),
    .rst_ni   (presetn_i),
    .clear_i  (state_q == ST_IDLE),
    .enable_i ((state_q == ST_REQ) || (state_q == ST_WAIT)),
    .expire_o (expire)
  );

  always_ff @(posedge pclk_i or negedge presetn_i) begin
    if (!presetn_i) begin
      state_q   <= ST_IDLE;
      req_vld_q <= 1'b0; wr_en_q <= 1'b0; rd_en_q <= 1'b0; non_sec_q <= 1'b0;
      addr_q    <= '0;   wdata_q <= '0;   be_q    <= '0;   rdata_q   <= '0;
      pready_q  <= 1'b0; err_q   <= 1'b0; to_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (setup) begin
          if (misalign || sec_viol || zero_strb) begin
            state_q  <= ST_RESP;
            pready_q <= 1'b1;
            err_q    <= misalign | sec_viol;
            rdata_q  <= '0;
          end else begin
            state_q   <= ST_REQ;
            req_vld_q <= 1'b1;
            wr_en_q   <= apb.pwrite;
            rd_en_q   <= ~apb.pwrite;
            addr_q    <= apb.paddr;
            wdata_q   <= apb.pwdata;
            be_q      <= apb.pwrite ? apb.pstrb : '0;
            non_sec_q <= apb.pprot[1];
          end
        end
        ST_REQ, ST_WAIT: begin
          req_vld_q <= 1'b0;
          if (done) begin
            state_q   <= ST_RESP;
            pready_q  <= 1'b1;
            rdata_q   <= (ack_vld_i && !wr_en_q) ? rd_data_i : '0;
            err_q     <= ack_vld_i ? err_i : 1'b1;
            to_q      <= ~ack_vld_i;
            wr_en_q   <= 1'b0; rd_en_q <= 1'b0; non_sec_q <= 1'b0;
            addr_q    <= '0;   wdata_q <= '0;   be_q      <= '0;
          end else begin
            state_q <= ST_WAIT;
          end
        end
        ST_RESP: begin
          state_q  <= ST_IDLE;
          pready_q <= 1'b0;
          err_q    <= 1'b0;
          rdata_q  <= '0;
          to_q     <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign apb.pready      = pready_q;
  assign apb.prdata      = rdata_q;
  assign apb.pslverr     = pready_q & err_q & error_report_en_i;
  assign req_vld_o       = req_vld_q;
  assign wr_en_o         = wr_en_q;
  assign rd_en_o         = rd_en_q;
  assign addr_o          = addr_q;
  assign wr_data_o       = wdata_q;
  assign wr_be_o         = be_q;
  assign non_sec_o       = non_sec_q;
  assign timeout_pulse_o = to_q;
endmodule

// File: tb/tb_apb4_reg_native_bridge.sv
// Randomised + directed bench for apb4_reg_native_bridge (TIMEOUT_CYCLES=8).
module tb_apb4_reg_native_bridge;
  localparam int AW = 48, DW = 32, SW = DW/8, TO = 8;

  logic pclk = 1'b0, presetn;
  logic req_vld, ack_vld, wr_en, rd_en, err, non_sec, dom_ns, rep_en, tmo;
  logic [AW-1:0] addr;
  logic [DW-1:0] wr_data, rd_data;
  logic [SW-1:0] wr_be;
  int errs = 0, checks = 0;

  // results of the last transfer
  int r_nreq, r_rdy, r_to;
  logic [AW-1:0] r_addr; logic [DW-1:0] r_wdata, r_prdata; logic [SW-1:0] r_be;
  logic r_wr, r_rd, r_ns, r_slverr, r_leak, r_hold, r_nat;

  apb4_reg_native_bridge_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) apb();

  apb4_reg_native_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO),
                           .TIMEOUT_WIDTH(16)) dut (
    .pclk_i(pclk), .presetn_i(presetn), .apb(apb),
    .req_vld_o(req_vld), .ack_vld_i(ack_vld), .wr_en_o(wr_en), .rd_en_o(rd_en),
    .addr_o(addr), .wr_data_o(wr_data), .wr_be_o(wr_be), .rd_data_i(rd_data),
    .err_i(err), .non_sec_o(non_sec), .domain_is_non_secure_i(dom_ns),
    .error_report_en_i(rep_en), .timeout_pulse_o(tmo));

  always #5 pclk = ~pclk;

  // One APB transfer with a native responder acking lat WAIT cycles after REQ (lat<0: never).
  task automatic xfer(input logic [AW-1:0] a, input logic wr, input logic [DW-1:0] wd,
                      input logic [SW-1:0] sb, input logic [2:0] prot, input int lat,
                      input logic aerr, input logic [DW-1:0] rd);
    int remain = -1;
    int c = 1;
    r_nreq = 0; r_rdy = -1; r_to = 0; r_leak = 0; r_hold = 0; r_nat = 0;
    r_prdata = '0; r_slverr = 0;
    @(posedge pclk); #1;
    apb.psel = 1; apb.penable = 0; apb.paddr = a; apb.pwrite = wr; apb.pwdata = wd;
    apb.pstrb = sb; apb.pprot = prot; rd_data = rd; err = aerr;
    while (c <= 40) begin
      @(negedge pclk);
      ack_vld = 0;
      if (req_vld) begin
        r_nreq++; r_addr = addr; r_wr = wr_en; r_rd = rd_en; r_be = wr_be;
        r_wdata = wr_data; r_ns = non_sec; remain = lat;
      end else if (remain > 0) remain--;
      if (tmo) r_to++;
      if (apb.pready) begin
        r_rdy = c; r_prdata = apb.prdata; r_slverr = apb.pslverr;
        if (req_vld || wr_en || rd_en || addr != 0 || wr_be != 0 || non_sec) r_nat = 1;
        break;
      end
      if (apb.prdata !== '0 || apb.pslverr !== 1'b0) r_leak = 1;
      if (r_nreq > 0 && !req_vld && addr !== r_addr) r_hold = 1;
      if (remain == 0) begin ack_vld = 1; remain = -1; end
      @(posedge pclk); #1;
      apb.penable = 1; c++;
    end
    @(posedge pclk); #1;
    apb.psel = 0; apb.penable = 0; ack_vld = 0;
  endtask

  task automatic test_reset;
    presetn = 0; #12;
    checks++; if ({req_vld, wr_en, rd_en, non_sec, tmo, apb.pready, apb.pslverr} !== 7'b0)
      begin errs++; $display("FAIL reset_ctrl got=%b exp=0", {req_vld, wr_en, rd_en, non_sec, tmo, apb.pready, apb.pslverr}); end
    checks++; if ({addr, wr_data, wr_be, apb.prdata} !== '0)
      begin errs++; $display("FAIL reset_data addr=%0h wd=%0h be=%0h prdata=%0h exp=0", addr, wr_data, wr_be, apb.prdata); end
    @(posedge pclk); #1; presetn = 1;
  endtask

  task automatic test_write_fast;
    xfer(48'h40, 1, 32'hDEADBEEF, 4'hF, 3'b000, 0, 0, '0);
    checks++; if (r_nreq !== 1) begin errs++; $display("FAIL wr_nreq got=%0d exp=1", r_nreq); end
    checks++; if ({r_wr, r_rd} !== 2'b10) begin errs++; $display("FAIL wr_type got=%b exp=10", {r_wr, r_rd}); end
    checks++; if (r_addr !== 48'h40 || r_be !== 4'hF || r_wdata !== 32'hDEADBEEF)
      begin errs++; $display("FAIL wr_fields addr=%0h be=%0h wd=%0h", r_addr, r_be, r_wdata); end
    checks++; if (r_rdy !== 3 || r_slverr !== 0) begin errs++; $display("FAIL wr_resp cyc=%0d exp=3 slverr=%b", r_rdy, r_slverr); end
  endtask

  task automatic test_read_wait;
    xfer(48'h80, 0, '0, 4'hF, 3'b000, 5, 0, 32'h12345678);
    checks++; if (r_nreq !== 1 || {r_wr, r_rd} !== 2'b01 || r_be !== 0)
      begin errs++; $display("FAIL rd_req n=%0d type=%b be=%0h", r_nreq, {r_wr, r_rd}, r_be); end
    checks++; if (r_rdy !== 8) begin errs++; $display("FAIL rd_latency got=%0d exp=8", r_rdy); end
    checks++; if (r_prdata !== 32'h12345678) begin errs++; $display("FAIL rd_data got=%0h exp=12345678", r_prdata); end
    checks++; if (r_leak !== 0 || r_hold !== 0 || r_nat !== 0)
      begin errs++; $display("FAIL rd_outside_resp leak=%b hold=%b nat=%b exp=0", r_leak, r_hold, r_nat); end
  endtask

  task automatic test_misaligned;
    for (int en = 1; en >= 0; en--) begin
      rep_en = en[0];
      xfer(48'h82, 0, '0, 4'hF, 3'b000, 0, 0, 32'hFFFF_FFFF);
      checks++; if (r_nreq !== 0 || r_rdy !== 2 || r_slverr !== en[0] || r_prdata !== 0)
        begin errs++; $display("FAIL misaligned_en%0d n=%0d cyc=%0d slverr=%b prdata=%0h", en, r_nreq, r_rdy, r_slverr, r_prdata); end
    end
    rep_en = 1;
  endtask

  task automatic test_timeout;
    xfer(48'h100, 0, '0, 4'hF, 3'b000, -1, 0, 32'hAAAA5555);
    checks++; if (r_to !== 1 || r_slverr !== 1 || r_prdata !== 0 || r_rdy !== 2 + TO)
      begin errs++; $display("FAIL timeout pulses=%0d slverr=%b prdata=%0h cyc=%0d exp=%0d", r_to, r_slverr, r_prdata, r_rdy, 2 + TO); end
    ack_vld = 1; @(negedge pclk);
    checks++; if (req_vld !== 0 || apb.pready !== 0 || tmo !== 0)
      begin errs++; $display("FAIL late_ack req=%b rdy=%b tmo=%b exp=0", req_vld, apb.pready, tmo); end
    @(posedge pclk); #1; ack_vld = 0;
    xfer(48'h104, 0, '0, 4'hF, 3'b000, 1, 0, 32'h0BADF00D);
    checks++; if (r_prdata !== 32'h0BADF00D || r_rdy !== 4 || r_to !== 0)
      begin errs++; $display("FAIL after_timeout prdata=%0h cyc=%0d to=%0d", r_prdata, r_rdy, r_to); end
    xfer(48'h108, 0, '0, 4'hF, 3'b000, TO - 1, 0, 32'h600DCAFE);
    checks++; if (r_to !== 0 || r_prdata !== 32'h600DCAFE || r_rdy !== 2 + TO || r_slverr !== 0)
      begin errs++; $display("FAIL ack_wins to=%0d prdata=%0h cyc=%0d slverr=%b", r_to, r_prdata, r_rdy, r_slverr); end
  endtask

  task automatic test_zero_strobe;
    xfer(48'h200, 1, 32'h1, 4'h0, 3'b000, 0, 1, '0);
    checks++; if (r_nreq !== 0 || r_rdy !== 2 || r_slverr !== 0)
      begin errs++; $display("FAIL zero_strb n=%0d cyc=%0d slverr=%b", r_nreq, r_rdy, r_slverr); end
  endtask

  task automatic test_security;
    dom_ns = 0;
    xfer(48'h300, 0, '0, 4'hF, 3'b010, 0, 0, 32'h5EC0);
`ifdef APB2REG_SEC_CHECK_EN
    checks++; if (r_nreq !== 0 || r_slverr !== 1 || r_rdy !== 2)
      begin errs++; $display("FAIL sec_viol n=%0d slverr=%b cyc=%0d", r_nreq, r_slverr, r_rdy); end
`else
    checks++; if (r_nreq !== 1 || r_ns !== 1 || r_prdata !== 32'h5EC0)
      begin errs++; $display("FAIL sec_off n=%0d ns=%b prdata=%0h", r_nreq, r_ns, r_prdata); end
`endif
    dom_ns = 1;
    xfer(48'h300, 0, '0, 4'hF, 3'b010, 0, 0, 32'h5EC1);
    checks++; if (r_nreq !== 1 || r_ns !== 1 || r_slverr !== 0 || r_prdata !== 32'h5EC1)
      begin errs++; $display("FAIL sec_ok n=%0d ns=%b slverr=%b prdata=%0h", r_nreq, r_ns, r_slverr, r_prdata); end
  endtask

  task automatic test_reset_mid;
    @(posedge pclk); #1;
    apb.psel = 1; apb.penable = 0; apb.paddr = 48'h400; apb.pwrite = 1; apb.pstrb = 4'h3;
    @(posedge pclk); #1; apb.penable = 1;
    @(negedge pclk); #2; presetn = 0; #1;
    checks++; if ({req_vld, wr_en, wr_be, addr, apb.pready} !== '0)
      begin errs++; $display("FAIL reset_mid req=%b wr=%b be=%0h addr=%0h rdy=%b exp=0", req_vld, wr_en, wr_be, addr, apb.pready); end
    apb.psel = 0; apb.penable = 0;
    @(posedge pclk); #1; presetn = 1;
    xfer(48'h404, 0, '0, 4'hF, 3'b000, 2, 0, 32'h77);
    checks++; if (r_prdata !== 32'h77 || r_rdy !== 5)
      begin errs++; $display("FAIL after_reset prdata=%0h cyc=%0d", r_prdata, r_rdy); end
  endtask

  // Reference: outcome derived from the transfer rules, not from the bridge state machine.
  task automatic test_random;
    for (int i = 0; i < 40; i++) begin
      logic [AW-1:0] a; logic wr, ae, viol, bad, zs; logic [DW-1:0] wd, rd, e_prd;
      logic [SW-1:0] sb; logic [2:0] prot; int lat, e_n, e_rdy, e_to; logic e_err;
      a = AW'({$urandom, $urandom}); if ($urandom_range(3) != 0) a[1:0] = 2'b00;
      wr = 1'($urandom); wd = $urandom; rd = $urandom; prot = 3'($urandom);
      sb = ($urandom_range(4) == 0) ? '0 : SW'($urandom);
      lat = $urandom_range(TO + 1) - 1; ae = 1'($urandom);
      rep_en = 1'($urandom); dom_ns = 1'($urandom);
`ifdef APB2REG_SEC_CHECK_EN
      viol = prot[1] & ~dom_ns;
`else
      viol = 0;
`endif
      bad = (a % (DW/8)) != 0 || viol; zs = wr && sb == 0;
      e_n = 0; e_rdy = 2; e_to = 0; e_prd = '0; e_err = bad;
      if (!bad && !zs) begin
        e_n = 1;
        if (lat < 0 || lat >= TO) begin e_rdy = 2 + TO; e_to = 1; e_err = 1; end
        else begin e_rdy = 3 + lat; e_err = ae; e_prd = wr ? '0 : rd; end
      end
      xfer(a, wr, wd, sb, prot, lat, ae, rd);
      checks++; if (r_nreq !== e_n || r_rdy !== e_rdy || r_to !== e_to)
        begin errs++; $display("FAIL rand%0d_flow n=%0d/%0d cyc=%0d/%0d to=%0d/%0d", i, r_nreq, e_n, r_rdy, e_rdy, r_to, e_to); end
      checks++; if (r_prdata !== e_prd || r_slverr !== (e_err & rep_en))
        begin errs++; $display("FAIL rand%0d_resp prdata=%0h/%0h slverr=%b/%b", i, r_prdata, e_prd, r_slverr, e_err & rep_en); end
      if (e_n == 1) begin
        checks++; if (r_addr !== a || {r_wr, r_rd} !== {wr, ~wr} || r_be !== (wr ? sb : '0) ||
                      r_wdata !== wd || r_ns !== prot[1] || r_hold || r_nat || r_leak)
          begin errs++; $display("FAIL rand%0d_req addr=%0h/%0h type=%b be=%0h ns=%b hold=%b nat=%b leak=%b",
                                 i, r_addr, a, {r_wr, r_rd}, r_be, r_ns, r_hold, r_nat, r_leak); end
      end
    end
  endtask

  initial begin
    apb.psel = 0; apb.penable = 0; apb.pwrite = 0; apb.paddr = '0; apb.pwdata = '0;
    apb.pstrb = '0; apb.pprot = '0; ack_vld = 0; rd_data = '0; err = 0;
    dom_ns = 1; rep_en = 1;
    test_reset();
    test_write_fast();
    test_read_wait();
    test_misaligned();
    test_timeout();
    test_zero_strobe();
    test_security();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
